sample_tx_scheduler: RTL and testbench

SAMPLE_TX_SCHEDULER -- requirements
Module: sample_tx_scheduler

---
 rtl/sample_tx_scheduler_if.sv | 48 ++++
 rtl/sample_tx_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_sample_tx_scheduler.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_tx_scheduler_if.sv
// ---------------------------------------------------------------------------
// sample_tx_scheduler_if
//
// Purpose: bundles the sensor, sample-memory, packetiser and radio signals
// of the sample/transmit scheduler into one connection.
//
// Signals:
//   sensor_enable  sched -> sensor   one-cycle sample strobe
//   sensor_data    sensor -> sched   sample, valid the cycle after the strobe
//   mem_addr       sched -> memory   4-bit address (shared by write and read)
//   mem_wdata      sched -> memory   write data
//   mem_write      sched -> memory   write strobe
//   mem_read       sched -> memory   read strobe, mem_rdata valid next cycle
//   mem_rdata      memory -> sched   read data
//   pkt_data       sched -> pktiser  byte to transmit
//   pkt_valid      sched -> pktiser  pkt_data valid
//   pkt_ready      pktiser -> sched  byte accepted when valid and ready
//   radio_enable   sched -> radio    radio power request
//   radio_busy     radio -> sched    radio occupied
//
// Modports: master = scheduler side, slave = peripheral side.
// ---------------------------------------------------------------------------
interface sample_tx_scheduler_if;
    logic       sensor_enable;
    logic [7:0] sensor_data;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_write;
    logic       mem_read;
    logic [7:0] mem_rdata;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       pkt_ready;
    logic       radio_enable;
    logic       radio_busy;

    modport master (
        output sensor_enable, mem_addr, mem_wdata, mem_write, mem_read,
               pkt_data, pkt_valid, radio_enable,
        input  sensor_data, mem_rdata, pkt_ready, radio_busy
    );

    modport slave (
        input  sensor_enable, mem_addr, mem_wdata, mem_write, mem_read,
               pkt_data, pkt_valid, radio_enable,
        output sensor_data, mem_rdata, pkt_ready, radio_busy
    );
endinterface

// File: rtl/sample_tx_scheduler.sv
// ---------------------------------------------------------------------------
// sample_tx_scheduler
//
// Purpose: periodically samples a sensor, stores the samples in a 16-entry
// external memory used as a circular FIFO, and once BATCH samples are held,
// powers the radio and streams them to a packetiser in write order.
//
// Parameters:
//   SAMPLE_PERIOD  clock cycles between sample ticks (2..65535)
//   BATCH          samples per transmitted batch (1..16)
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst_n       asynchronous active-low reset
//   enable      run request
//   bus         sensor / memory / packetiser / radio signals (master side)
//   batch_done  one-cycle pulse when a batch has been fully sent
//   overrun     sticky flag: a sample tick arrived while busy and was skipped
//
// Every output is driven straight from a register.
// ---------------------------------------------------------------------------
module sample_tx_scheduler #(
    parameter int SAMPLE_PERIOD = 16,
    parameter int BATCH         = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    sample_tx_scheduler_if.master bus,
    output logic                  batch_done,
    output logic                  overrun
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        SAMPLE,
        CAPTURE,
        FLUSH_WAIT,
        READ,
        SEND,
        DONE
    } state_t;

    localparam logic [15:0] TICK_RELOAD = 16'(SAMPLE_PERIOD - 1);
    localparam logic [4:0]  BATCH_LEN   = 5'(BATCH);

    state_t      state_q, state_d;
    logic [15:0] tick_q, tick_d;
    logic [3:0]  wr_ptr_q, wr_ptr_d;
    logic [3:0]  rd_ptr_q, rd_ptr_d;
    logic [4:0]  fill_q, fill_d;
    logic        overrun_q, overrun_d;
    logic        sensor_enable_q, sensor_enable_d;
    logic [3:0]  mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        mem_write_q, mem_write_d;
    logic        mem_read_q, mem_read_d;
    logic [7:0]  pkt_data_q, pkt_data_d;
    logic        pkt_valid_q, pkt_valid_d;
    logic        radio_enable_q, radio_enable_d;
    logic        batch_done_q, batch_done_d;
    logic        tick;

    // The tick counter only runs outside IDLE, so a tick is never seen there.
    assign tick = (state_q != IDLE) && (tick_q == 16'd0);

    always_comb begin
        state_d         = state_q;
        tick_d          = tick_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        fill_d          = fill_q;
        overrun_d       = overrun_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_write_d     = 1'b0;
        pkt_data_d      = pkt_data_q;
        pkt_valid_d     = pkt_valid_q;
        sensor_enable_d = 1'b0;
        mem_read_d      = 1'b0;
        radio_enable_d  = 1'b0;
        batch_done_d    = 1'b0;

        if (state_q == IDLE) begin
            if (enable) begin
                tick_d = TICK_RELOAD;
            end
        end else if (tick) begin
            tick_d = TICK_RELOAD;
        end else begin
            tick_d = tick_q - 16'd1;
        end

        // A tick anywhere but WAIT cannot be serviced: the sample is lost.
        if (tick && (state_q != WAIT)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (tick) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // sensor_data is valid now; the write strobe is registered
                // and so appears on the bus in the following cycle.
                mem_write_d = 1'b1;
                mem_addr_d  = wr_ptr_q;
                mem_wdata_d = bus.sensor_data;
                wr_ptr_d    = wr_ptr_q + 4'd1;
                fill_d      = fill_q + 5'd1;
                state_d     = (fill_d == BATCH_LEN) ? FLUSH_WAIT : WAIT;
            end
            FLUSH_WAIT: begin
                if (!bus.radio_busy) begin
                    state_d = READ;
                end
            end
            READ: begin
                state_d = SEND;
            end
            SEND: begin
                // pkt_valid is low on entry, so it doubles as the
                // "read data already latched" flag.
                if (!pkt_valid_q) begin
                    pkt_data_d  = bus.mem_rdata;
                    pkt_valid_d = 1'b1;
                end else if (bus.pkt_ready) begin
                    pkt_valid_d = 1'b0;
                    rd_ptr_d    = rd_ptr_q + 4'd1;
                    fill_d      = fill_q - 5'd1;
                    state_d     = (fill_q == 5'd1) ? DONE : READ;
                end
            end
            DONE: begin
                state_d = enable ? WAIT : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes decoded from the next state so they are registered and
        // line up exactly with the state they belong to.
        sensor_enable_d = (state_d == SAMPLE);
        batch_done_d    = (state_d == DONE);
        if (state_d == READ) begin
            mem_read_d = 1'b1;
            mem_addr_d = rd_ptr_d;
        end
        radio_enable_d = (state_d == FLUSH_WAIT) || (state_d == READ) ||
                         (state_d == SEND) || (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            tick_q          <= 16'd0;
            wr_ptr_q        <= 4'd0;
            rd_ptr_q        <= 4'd0;
            fill_q          <= 5'd0;
            overrun_q       <= 1'b0;
            sensor_enable_q <= 1'b0;
            mem_addr_q      <= 4'd0;
            mem_wdata_q     <= 8'd0;
            mem_write_q     <= 1'b0;
            mem_read_q      <= 1'b0;
            pkt_data_q      <= 8'd0;
            pkt_valid_q     <= 1'b0;
            radio_enable_q  <= 1'b0;
            batch_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            tick_q          <= tick_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            fill_q          <= fill_d;
            overrun_q       <= overrun_d;
            sensor_enable_q <= sensor_enable_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_write_q     <= mem_write_d;
            mem_read_q      <= mem_read_d;
            pkt_data_q      <= pkt_data_d;
            pkt_valid_q     <= pkt_valid_d;
            radio_enable_q  <= radio_enable_d;
            batch_done_q    <= batch_done_d;
        end
    end

    assign bus.sensor_enable = sensor_enable_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.mem_write     = mem_write_q;
    assign bus.mem_read      = mem_read_q;
    assign bus.pkt_data      = pkt_data_q;
    assign bus.pkt_valid     = pkt_valid_q;
    assign bus.radio_enable  = radio_enable_q;
    assign batch_done        = batch_done_q;
    assign overrun           = overrun_q;

endmodule

// File: tb/tb_sample_tx_scheduler.sv
// Bench for sample_tx_scheduler with SAMPLE_PERIOD=4, BATCH=2.
// A transaction-level model (sample queue, FIFO of stored bytes, counters)
// follows the bus every cycle; a cycle table covers the first batch, and
// short hand-written sequences cover stall, radio-busy and async reset.
module tb_sample_tx_scheduler;
    localparam int P = 4;
    localparam int B = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic batch_done;
    logic overrun;

    sample_tx_scheduler_if bus_if ();

    sample_tx_scheduler #(.SAMPLE_PERIOD(P), .BATCH(B)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .bus        (bus_if),
        .batch_done (batch_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // environment / model state
    logic [7:0] mem [16];
    logic [7:0] sensor_q [$];
    logic [7:0] fifo_q [$];
    int   cyc, last_se, wr_cnt, sent, since_bd, batches;
    bit   en_cont, se_prev, prev_pv, auto_sensor, saw15, wrapped;
    logic [7:0] prev_pd;

    typedef struct {
        logic        en;
        logic [7:0]  sd;
        logic [26:0] exp;
    } vec_t;

    localparam int NROWS = 22;
    vec_t vec [NROWS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [26:0] outs();
        return {bus_if.sensor_enable, bus_if.mem_write, bus_if.mem_read, bus_if.mem_addr,
                bus_if.mem_wdata, bus_if.pkt_valid, bus_if.pkt_data, bus_if.radio_enable,
                batch_done, overrun};
    endfunction

    function automatic vec_t mk(input logic en, input logic [7:0] sd,
                                input logic se, input logic mw, input logic mr,
                                input logic [3:0] addr, input logic [7:0] wd,
                                input logic pv, input logic [7:0] pd,
                                input logic re, input logic bd, input logic ov);
        vec_t v;
        v.en  = en;
        v.sd  = sd;
        v.exp = {se, mw, mr, addr, wd, pv, pd, re, bd, ov};
        return v;
    endfunction

    task automatic model_reset();
        sensor_q.delete();
        fifo_q.delete();
        wr_cnt = 0; sent = 0; since_bd = 0; batches = 0;
        last_se = 0; en_cont = 0; se_prev = 0; prev_pv = 0; prev_pd = 8'h00;
        saw15 = 0; wrapped = 0;
    endtask

    // Observe one cycle of bus activity and update the model.
    task automatic monitor();
        logic [8:0] e;
        cyc++;
        if (!enable) en_cont = 0;
        if (se_prev) sensor_q.push_back(bus_if.sensor_data);
        se_prev = bus_if.sensor_enable;
        if (bus_if.sensor_enable) begin
            if (en_cont) check("se_spacing", 32'((cyc - last_se) % P), 32'd0);
            en_cont = 1;
            last_se = cyc;
            if (auto_sensor) bus_if.sensor_data = 8'($urandom);
        end
        if (bus_if.mem_write) begin
            mem[bus_if.mem_addr] = bus_if.mem_wdata;
            check("wr_addr", 32'(bus_if.mem_addr), 32'(wr_cnt % 16));
            if (sensor_q.size() > 0) e = {1'b0, sensor_q.pop_front()};
            else e = 9'h100;
            check("wr_data", {23'd0, 1'b0, bus_if.mem_wdata}, {23'd0, e});
            fifo_q.push_back(bus_if.mem_wdata);
            if (bus_if.mem_addr == 4'd15) saw15 = 1;
            if (bus_if.mem_addr == 4'd0 && saw15) wrapped = 1;
            wr_cnt++;
        end
        // pkt_ready still holds the value that was sampled at the last edge
        if (prev_pv && bus_if.pkt_ready) begin
            if (fifo_q.size() > 0) e = {1'b0, fifo_q.pop_front()};
            else e = 9'h100;
            check("pkt_byte", {23'd0, 1'b0, prev_pd}, {23'd0, e});
            sent++;
            since_bd++;
        end else if (prev_pv) begin
            check("pkt_hold", {23'd0, bus_if.pkt_valid, bus_if.pkt_data}, {23'd0, 1'b1, prev_pd});
        end
        if (bus_if.mem_read) begin
            bus_if.mem_rdata = mem[bus_if.mem_addr];
            check("rd_addr", 32'(bus_if.mem_addr), 32'(sent % 16));
        end
        if (bus_if.pkt_valid || bus_if.mem_read) check("radio_on", 32'(bus_if.radio_enable), 32'd1);
        if (batch_done) begin
            check("batch_len", 32'(since_bd), 32'(B));
            since_bd = 0;
            batches++;
        end
        prev_pv = bus_if.pkt_valid;
        prev_pd = bus_if.pkt_data;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        bus_if.sensor_data = 8'h00;
        bus_if.mem_rdata = 8'h00;
        bus_if.radio_busy = 1'b0;
        bus_if.pkt_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_outputs", {5'd0, outs()}, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        int b0;
        cyc = 0;
        auto_sensor = 0;

        // cycle table: first batch, radio free, packetiser always ready
        //               en  sd     se mw mr addr  wd     pv pd     re bd ov
        vec[0]  = mk(1, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 8'h00, 0, 0, 0);
        vec[1]  = mk(1, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 8'h00, 0, 0, 0);
        vec[2]  = mk(1, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 8'h00, 0, 0, 0);
        vec[3]  = mk(1, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 8'h00, 0, 0, 0);
        vec[4]  = mk(1, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 8'h00, 0, 0, 0);
        vec[5]  = mk(1, 8'h11, 1, 0, 0, 4'd0, 8'h00, 0, 8'h00, 0, 0, 0);
        vec[6]  = mk(1, 8'h11, 0, 0, 0, 4'd0, 8'h00, 0, 8'h00, 0, 0, 0);
        vec[7]  = mk(1, 8'h11, 0, 1, 0, 4'd0, 8'h11, 0, 8'h00, 0, 0, 0);
        vec[8]  = mk(1, 8'h11, 0, 0, 0, 4'd0, 8'h11, 0, 8'h00, 0, 0, 0);
        vec[9]  = mk(1, 8'h22, 1, 0, 0, 4'd0, 8'h11, 0, 8'h00, 0, 0, 0);
        vec[10] = mk(1, 8'h22, 0, 0, 0, 4'd0, 8'h11, 0, 8'h00, 0, 0, 0);
        vec[11] = mk(1, 8'h22, 0, 1, 0, 4'd1, 8'h22, 0, 8'h00, 1, 0, 0);
        vec[12] = mk(1, 8'h22, 0, 0, 1, 4'd0, 8'h22, 0, 8'h00, 1, 0, 0);
        vec[13] = mk(1, 8'h22, 0, 0, 0, 4'd0, 8'h22, 0, 8'h00, 1, 0, 1);
        vec[14] = mk(1, 8'h22, 0, 0, 0, 4'd0, 8'h22, 1, 8'h11, 1, 0, 1);
        vec[15] = mk(1, 8'h22, 0, 0, 1, 4'd1, 8'h22, 0, 8'h11, 1, 0, 1);
        vec[16] = mk(1, 8'h22, 0, 0, 0, 4'd1, 8'h22, 0, 8'h11, 1, 0, 1);
        vec[17] = mk(1, 8'h22, 0, 0, 0, 4'd1, 8'h22, 1, 8'h22, 1, 0, 1);
        vec[18] = mk(1, 8'h22, 0, 0, 0, 4'd1, 8'h22, 0, 8'h22, 1, 1, 1);
        vec[19] = mk(1, 8'h22, 0, 0, 0, 4'd1, 8'h22, 0, 8'h22, 0, 0, 1);
        vec[20] = mk(1, 8'h22, 0, 0, 0, 4'd1, 8'h22, 0, 8'h22, 0, 0, 1);
        vec[21] = mk(1, 8'h22, 1, 0, 0, 4'd1, 8'h22, 0, 8'h22, 0, 0, 1);

        do_reset();
        bus_if.pkt_ready = 1'b1;
        for (int c = 0; c < NROWS; c++) begin
            step();
            check($sformatf("vec[%0d]", c), {5'd0, outs()}, {5'd0, vec[c].exp});
            enable = vec[c].en;
            bus_if.sensor_data = vec[c].sd;
        end

        // packetiser stalls for 10 cycles in SEND
        do_reset();
        auto_sensor = 1;
        enable = 1'b1;
        for (int i = 0; i < 100 && !bus_if.pkt_valid; i++) step();
        check("stall_reach", 32'(bus_if.pkt_valid), 32'd1);
        prev_pd = bus_if.pkt_data;
        begin
            logic [7:0] d0;
            d0 = bus_if.pkt_data;
            for (int i = 0; i < 10; i++) begin
                step();
                check("stall_stable", {23'd0, bus_if.pkt_valid, bus_if.pkt_data}, {23'd0, 1'b1, d0});
            end
        end
        check("stall_overrun", 32'(overrun), 32'd1);
        bus_if.pkt_ready = 1'b1;
        repeat (40) step();

        // radio busy for 20 cycles while waiting to flush
        do_reset();
        enable = 1'b1;
        bus_if.radio_busy = 1'b1;
        bus_if.pkt_ready = 1'b1;
        for (int i = 0; i < 100 && !bus_if.radio_enable; i++) step();
        check("busy_reach", 32'(bus_if.radio_enable), 32'd1);
        for (int i = 0; i < 20; i++) begin
            step();
            check("busy_hold", {30'd0, bus_if.mem_read, bus_if.radio_enable}, 32'd1);
        end
        check("busy_overrun", 32'(overrun), 32'd1);
        bus_if.radio_busy = 1'b0;
        for (int i = 0; i < 10 && !bus_if.mem_read; i++) step();
        check("busy_release", 32'(bus_if.mem_read), 32'd1);
        repeat (30) step();

        // asynchronous reset in the middle of SEND
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 100 && !bus_if.pkt_valid; i++) step();
        check("mid_send", {30'd0, bus_if.pkt_valid, bus_if.radio_enable}, 32'd3);
        rst_n = 1'b0;
        #1;
        check("async_reset", {29'd0, bus_if.pkt_valid, bus_if.radio_enable, overrun}, 32'd0);
        model_reset();
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b1;
        bus_if.pkt_ready = 1'b1;
        for (int i = 0; i < 50 && !bus_if.mem_write; i++) step();
        check("restart_addr", {27'd0, bus_if.mem_write, bus_if.mem_addr}, {27'd0, 1'b1, 4'd0});

        // randomized traffic checked by the transaction model
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            step();
            enable = ($urandom_range(0, 99) >= 3);
            bus_if.radio_busy = ($urandom_range(0, 3) == 0);
            bus_if.pkt_ready = ($urandom_range(0, 2) != 0);
        end
        enable = 1'b0;
        bus_if.radio_busy = 1'b0;
        bus_if.pkt_ready = 1'b1;
        repeat (60) step();
        check("batch_count", 32'(batches >= 9), 32'd1);
        check("ptr_wrap", 32'(wrapped), 32'd1);
        check("drain_sent", 32'(sent % B), 32'd0);
        check("drain_partial", 32'(fifo_q.size() < B), 32'd1);

        // resume after idle: any leftover partial batch goes out first
        b0 = batches;
        enable = 1'b1;
        for (int i = 0; i < 100 && batches == b0; i++) step();
        check("resume_batch", 32'(batches > b0), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
